// File: rtl/mux3_arbiter.sv
// Round-robin arbiter owning a 3-input 16-bit bus mux; grant one cycle after req, all outputs registered.
// No preemption: owner keeps the bus until it drops req or reaches MAX_HOLD, then TURN+IDLE precede next grant.
module mux3_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] control,
  output logic       bus_valid,
  output logic [7:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] control_q, control_d;
  logic       valid_q, valid_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] last_q, last_d;

  logic [1:0] win;
  logic       any_req;
  logic       owner_req;
  logic       release_now;

  assign any_req     = |req;
  assign owner_req   = |(req & grant_q);
  assign release_now = !owner_req || (hold_q == MAX_HOLD_C);

  // Search begins one past the last owner and wraps 2 -> 0.
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_now) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    control_d = control_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d   = 3'b001 << win;
          control_d = win;
          valid_d   = 1'b1;
          hold_d    = 8'd1;
          last_d    = win;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_d = 3'b000;
          valid_d = 1'b0;
          hold_d  = 8'd0;
        end else begin
          hold_d  = hold_q + 8'd1;
        end
      end
      default: begin
        grant_d = 3'b000;
        valid_d = 1'b0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // Last owner resets to 2 so requester 0 is searched first after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q   <= 3'b000;
      control_q <= 2'b00;
      valid_q   <= 1'b0;
      hold_q    <= 8'd0;
      last_q    <= 2'd2;
    end else begin
      grant_q   <= grant_d;
      control_q <= control_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  assign grant     = grant_q;
  assign control   = control_q;
  assign bus_valid = valid_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux3_arbiter.sv
// Directed bench for mux3_arbiter: one instance at MAX_HOLD=4, one at MAX_HOLD=1.
module tb_mux3_arbiter;

  logic       clock;
  logic       reset_n;
  logic [2:0] req_a, req_b;
  logic [2:0] grant_a, grant_b;
  logic [1:0] control_a, control_b;
  logic       valid_a, valid_b;
  logic [7:0] hold_a, hold_b;

  int err_cnt = 0;
  int chk_cnt = 0;

  mux3_arbiter #(.MAX_HOLD(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .req(req_a), .grant(grant_a),
    .control(control_a), .bus_valid(valid_a), .hold_cnt(hold_a)
  );

  mux3_arbiter #(.MAX_HOLD(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .req(req_b), .grant(grant_b),
    .control(control_b), .bus_valid(valid_b), .hold_cnt(hold_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input int g, input int c, input int v, input int h);
    chk({tag, ".grant"}, int'(grant_a), g);
    chk({tag, ".control"}, int'(control_a), c);
    chk({tag, ".valid"}, int'(valid_a), v);
    chk({tag, ".hold"}, int'(hold_a), h);
  endtask

  task automatic chk_b(input string tag, input int g, input int c, input int v, input int h);
    chk({tag, ".grant"}, int'(grant_b), g);
    chk({tag, ".control"}, int'(control_b), c);
    chk({tag, ".valid"}, int'(valid_b), v);
    chk({tag, ".hold"}, int'(hold_b), h);
  endtask

  initial begin
    int owners[4] = '{0, 1, 2, 0};
    reset_n = 1'b0;
    req_a   = 3'b000;
    req_b   = 3'b000;
    step();
    step();
    chk_a("rst_a", 0, 0, 0, 0);
    chk_b("rst_b", 0, 0, 0, 0);

    // Full rotation with all requesting.
    reset_n = 1'b1;
    req_a   = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 4; c++) begin
        step();
        chk_a($sformatf("rr%0d_c%0d", k, c), 1 << owners[k], owners[k], 1, c);
      end
      if (k < 3) begin
        for (int z = 0; z < 2; z++) begin
          step();
          chk_a($sformatf("rr%0d_gap%0d", k, z), 0, owners[k], 0, 0);
        end
      end
    end
    req_a = 3'b000;
    step();
    chk_a("rr_turn", 0, 0, 0, 0);
    step();
    chk_a("rr_idle", 0, 0, 0, 0);

    // Early release by owner 1.
    req_a = 3'b010;
    step();
    chk_a("rel_c1", 3'b010, 1, 1, 1);
    step();
    chk_a("rel_c2", 3'b010, 1, 1, 2);
    req_a = 3'b000;
    step();
    chk_a("rel_turn", 0, 1, 0, 0);
    step();
    chk_a("rel_idle", 0, 1, 0, 0);

    // Sole requester 2 is forced off at MAX_HOLD and regains the bus.
    req_a = 3'b100;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk_a($sformatf("solo_c%0d", c), 3'b100, 2, 1, c);
    end
    step();
    chk_a("solo_turn", 0, 2, 0, 0);
    step();
    chk_a("solo_idle", 0, 2, 0, 0);
    step();
    chk_a("solo_regrant", 3'b100, 2, 1, 1);
    req_a = 3'b000;
    step();
    step();
    chk_a("solo_end", 0, 2, 0, 0);

    // No preemption of owner 0 by requester 1.
    req_a = 3'b001;
    step();
    chk_a("npre_c1", 3'b001, 0, 1, 1);
    step();
    chk_a("npre_c2", 3'b001, 0, 1, 2);
    req_a = 3'b011;
    step();
    chk_a("npre_c3", 3'b001, 0, 1, 3);
    step();
    chk_a("npre_c4", 3'b001, 0, 1, 4);
    step();
    chk_a("npre_turn", 0, 0, 0, 0);
    step();
    chk_a("npre_idle", 0, 0, 0, 0);
    step();
    chk_a("npre_next", 3'b010, 1, 1, 1);
    req_a = 3'b000;
    step();
    step();

    // Asynchronous reset mid-grant.
    req_a = 3'b100;
    step();
    chk_a("ar_pre", 3'b100, 2, 1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_a("ar_abort", 0, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    req_a   = 3'b110;
    step();
    chk_a("ar_first", 3'b010, 1, 1, 1);
    req_a = 3'b000;

    // MAX_HOLD=1 alternation on the second instance.
    req_b = 3'b101;
    step();
    chk_b("mh1_g0", 3'b001, 0, 1, 1);
    step();
    chk_b("mh1_t0", 0, 0, 0, 0);
    step();
    chk_b("mh1_i0", 0, 0, 0, 0);
    step();
    chk_b("mh1_g1", 3'b100, 2, 1, 1);
    step();
    chk_b("mh1_t1", 0, 2, 0, 0);
    step();
    chk_b("mh1_i1", 0, 2, 0, 0);
    step();
    chk_b("mh1_g2", 3'b001, 0, 1, 1);
    req_b = 3'b000;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
